mem_port_arbiter: RTL and testbench

Shares the core's single-ported memory between the instruction-fetch path and the load/store path. It sits between the core's fetch and LSU request ports and the memory. It arbitrates between them, sequences each access through a registered request/acknowledge handshake, and returns read data to the winning requester. A bus timeout converts a hung memory access into an error completion instead of a deadlock.

---
 rtl/mem_port_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between instruction fetch (i) and load/store (d).
// Latency: 3 cycles per access with zero-wait memory (IDLE grant, BUSY, RESP ack), +1 per wait cycle.
// Backpressure: requesters hold req until their one-cycle ack; a hung memory is cut off after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_RESP_I = 3'd3,
    S_RESP_D = 3'd4
  } state_t;

  // TIMEOUT of zero means wait for mem_ack forever.
  localparam bit         TMO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_d;
  logic [7:0]  r_tcnt;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [29:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic        r_i_ack;
  logic        r_i_err;
  logic [31:0] r_i_rdata;
  logic        r_d_ack;
  logic        r_d_err;
  logic [31:0] r_d_rdata;

  logic        w_grant_i;
  logic        w_grant_d;
  logic        w_busy;
  logic        w_done;
  logic        w_tout;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Arbitration, completion/timeout detection and next state.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_tout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Under contention the port that did not win last time gets the slot.
        if (d_req && (!i_req || !r_last_d)) begin
          w_grant_d = 1'b1;
          w_next    = S_BUSY_D;
        end else if (i_req) begin
          w_grant_i = 1'b1;
          w_next    = S_BUSY_I;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        w_busy = 1'b1;
        // A late mem_ack in the final allowed cycle still counts as success.
        w_done = mem_ack;
        w_tout = !mem_ack && TMO_EN && (r_tcnt == TMO_LAST);
        if (w_done || w_tout) begin
          w_next = (r_state == S_BUSY_I) ? S_RESP_I : S_RESP_D;
        end
      end
      S_RESP_I, S_RESP_D: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Memory-side request registers: loaded at grant, strobe dropped at completion or timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 30'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
    end else if (w_grant_d) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= d_we;
      r_mem_addr  <= d_addr;
      r_mem_wdata <= d_wdata;
      r_mem_be    <= d_we ? d_be : 4'b0000;
    end else if (w_grant_i) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= i_addr;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'b0000;
    end else if (w_done || w_tout) begin
      // Write qualifiers are cleared too so an abandoned store cannot linger on the bus.
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_be  <= 4'b0000;
    end
  end

  // Fairness bit and BUSY cycle counter for the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b0;
      r_tcnt   <= 8'd0;
    end else if (w_grant_d || w_grant_i) begin
      r_last_d <= w_grant_d;
      r_tcnt   <= 8'd0;
    end else if (w_busy && !w_done && !w_tout) begin
      r_tcnt <= r_tcnt + 8'd1;
    end
  end

  // Fetch response: one-cycle ack, read data held until the next fetch completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_i_rdata <= 32'd0;
    end else begin
      r_i_ack <= 1'b0;
      r_i_err <= 1'b0;
      if (r_state == S_BUSY_I) begin
        if (w_done) begin
          r_i_ack   <= 1'b1;
          r_i_rdata <= mem_rdata;
        end else if (w_tout) begin
          r_i_ack   <= 1'b1;
          r_i_err   <= 1'b1;
          r_i_rdata <= 32'd0;
        end
      end
    end
  end

  // Load/store response: stores capture mem_rdata as well, the value is simply unused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= 32'd0;
    end else begin
      r_d_ack <= 1'b0;
      r_d_err <= 1'b0;
      if (r_state == S_BUSY_D) begin
        if (w_done) begin
          r_d_ack   <= 1'b1;
          r_d_rdata <= mem_rdata;
        end else if (w_tout) begin
          r_d_ack   <= 1'b1;
          r_d_err   <= 1'b1;
          r_d_rdata <= 32'd0;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

  assign i_ack     = r_i_ack;
  assign i_err     = r_i_err;
  assign i_rdata   = r_i_rdata;
  assign d_ack     = r_d_ack;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: random requesters and memory, checked against a transaction-level model.
// The model schedules each access as a window of cycles (grant, memory window, ack) from its wait count.
// Summary line reports comparisons made and miscompares.
module tb_mem_port_arbiter;

  localparam int TMO   = 4;
  localparam int NEVER = 32'h3fffffff;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [29:0] i_addr;
  logic        i_ack;
  logic        i_err;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  // Requester model, index 0 = fetch, 1 = load/store.
  bit          pend [2];
  logic [29:0] q_addr [2];
  logic        q_we [2];
  logic [31:0] q_wdata [2];
  logic [3:0]  q_be [2];
  int          q_ack [2];
  int          rate [2];

  // Current transaction: granted in cycle t_g, memory window t_g+1..t_g+t_k, ack in t_ack.
  bit          t_vld;
  int          t_who, t_g, t_n, t_k, t_ack;
  bit          t_err;
  logic [29:0] t_addr;
  logic        t_we;
  logic [31:0] t_wdata;
  logic [3:0]  t_be;
  logic [31:0] t_rdata;

  int          cyc;
  int          idle_cyc;
  bit          last_d;
  int          fix_n;
  int          force_i_addr;
  logic [31:0] exp_rd [2];

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      pend[r]   = 1'b0;
      q_addr[r] = '0;
      q_we[r]   = 1'b0;
      q_wdata[r] = '0;
      q_be[r]   = '0;
      q_ack[r]  = NEVER;
      exp_rd[r] = '0;
    end
    t_vld  = 1'b0;
    last_d = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  // Decide this cycle's requester, arbiter and memory behaviour, then drive the inputs.
  task automatic drive_cycle();
    int w;
    int n;
    for (int r = 0; r < 2; r++) begin
      if (pend[r] && cyc > q_ack[r]) pend[r] = 1'b0;
      if (!pend[r] && $urandom_range(99) < rate[r]) begin
        pend[r]    = 1'b1;
        q_ack[r]   = NEVER;
        q_addr[r]  = 30'($urandom);
        q_we[r]    = (r == 1) ? 1'($urandom) : 1'b0;
        q_wdata[r] = (r == 1) ? $urandom : 32'd0;
        q_be[r]    = (r == 1) ? 4'($urandom) : 4'd0;
        if (r == 0 && force_i_addr >= 0) begin
          q_addr[0]    = 30'(force_i_addr);
          force_i_addr = -1;
        end
      end
    end
    if (cyc == idle_cyc) begin
      if (pend[0] || pend[1]) begin
        if (pend[0] && pend[1]) w = last_d ? 0 : 1;
        else                    w = pend[1] ? 1 : 0;
        last_d  = (w == 1);
        n       = (fix_n >= 0) ? fix_n : int'($urandom_range(6));
        t_vld   = 1'b1;
        t_who   = w;
        t_g     = cyc;
        t_n     = n;
        t_err   = (TMO != 0) && (n >= TMO);
        t_k     = t_err ? TMO : n + 1;
        t_ack   = cyc + t_k + 1;
        idle_cyc = t_ack + 1;
        q_ack[w] = t_ack;
        t_addr  = q_addr[w];
        t_we    = q_we[w];
        t_wdata = q_wdata[w];
        t_be    = q_be[w];
        t_rdata = '0;
      end else begin
        idle_cyc = cyc + 1;
      end
    end
    mem_rdata = $urandom;
    if (t_vld && cyc > t_g && cyc <= t_g + t_k) begin
      mem_ack = (cyc == t_g + t_n + 1);
      if (mem_ack) t_rdata = mem_rdata;
    end else begin
      // Stray acks outside an access must be ignored.
      mem_ack = ($urandom_range(3) == 0);
    end
    i_req   = pend[0];
    i_addr  = q_addr[0];
    d_req   = pend[1];
    d_we    = q_we[1];
    d_addr  = q_addr[1];
    d_wdata = q_wdata[1];
    d_be    = q_be[1];
  endtask

  task automatic check_cycle();
    bit in_win;
    bit ack_now;
    in_win  = t_vld && cyc > t_g && cyc <= t_g + t_k;
    ack_now = t_vld && cyc == t_ack;
    chk("mem_req", 32'(mem_req), 32'(in_win));
    if (in_win) begin
      chk("mem_addr", 32'(mem_addr), 32'(t_addr));
      chk("mem_we",   32'(mem_we),   32'(t_we));
      chk("mem_be",   32'(mem_be),   t_we ? 32'(t_be) : 32'd0);
      if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
    end
    if (ack_now) exp_rd[t_who] = t_err ? 32'd0 : t_rdata;
    chk("i_ack", 32'(i_ack), 32'(ack_now && t_who == 0));
    chk("d_ack", 32'(d_ack), 32'(ack_now && t_who == 1));
    if (ack_now && t_who == 0) chk("i_err", 32'(i_err), 32'(t_err));
    if (ack_now && t_who == 1) chk("d_err", 32'(d_err), 32'(t_err));
    chk("i_rdata", i_rdata, exp_rd[0]);
    chk("d_rdata", d_rdata, exp_rd[1]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive_cycle();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, "_mem_be"},    32'(mem_be),    32'd0);
    chk({tag, "_i_ack"},     32'(i_ack),     32'd0);
    chk({tag, "_i_err"},     32'(i_err),     32'd0);
    chk({tag, "_i_rdata"},   i_rdata,        32'd0);
    chk({tag, "_d_ack"},     32'(d_ack),     32'd0);
    chk({tag, "_d_err"},     32'(d_err),     32'd0);
    chk({tag, "_d_rdata"},   d_rdata,        32'd0);
  endtask

  task automatic set_mode(input int ri, input int rd, input int fn);
    rate[0] = ri;
    rate[1] = rd;
    fix_n   = fn;
  endtask

  initial begin
    bit found;
    cyc          = 0;
    force_i_addr = -1;
    set_mode(0, 0, -1);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst0");
    reset    = 1'b0;
    idle_cyc = cyc + 1;

    // Continuous contention with zero-wait memory: grants alternate d, i, d, i.
    set_mode(100, 100, 0);
    repeat (30) step();
    // Fetch that never gets mem_ack: timeout error, then a normal load/store.
    set_mode(100, 0, 7);
    repeat (12) step();
    set_mode(0, 100, 1);
    repeat (12) step();
    // mem_ack arriving in the last allowed cycle beats the timeout.
    set_mode(100, 100, 3);
    repeat (24) step();
    // Random traffic with wait counts on both sides of the timeout.
    set_mode(40, 40, -1);
    repeat (2000) step();

    // Reset in the middle of a load/store access.
    set_mode(0, 100, 2);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      step();
      found = t_vld && t_who == 1 && cyc > t_g && cyc <= t_g + t_k;
    end
    chk("busy_d_reached", 32'(found), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_zero("rst_hold");
    reset    = 1'b0;
    idle_cyc = cyc + 1;

    // Fetch alone at 0x10 after reset.
    set_mode(100, 0, 0);
    force_i_addr = 32'h10;
    repeat (2) step();
    chk("post_rst_addr", 32'(mem_addr), 32'h10);
    repeat (10) step();

    set_mode(50, 50, -1);
    repeat (500) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
